tl_ctrl: RTL and testbench



---
 rtl/tl_ctrl_if.sv | 24 ++
 rtl/tl_ctrl.sv | 99 +++++++++
 tb/tb_tl_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_ctrl_if.sv
// Controller-side bundle for the traffic-light sequencer: run/pedestrian inputs,
// datapath done flags, and the phase/clear/ack/cycle outputs.
interface tl_ctrl_if #(
    parameter int STATE_W = 7,
    parameter int CYC_W   = 8
);
    logic               en;
    logic               ped_req;
    logic [STATE_W-1:0] done_state;
    logic [STATE_W-1:0] curr_state;
    logic               dp_cnt_rst;
    logic               ped_ack;
    logic [CYC_W-1:0]   cycle_cnt;

    modport master (
        output en, ped_req, done_state,
        input  curr_state, dp_cnt_rst, ped_ack, cycle_cnt
    );

    modport slave (
        input  en, ped_req, done_state,
        output curr_state, dp_cnt_rst, ped_ack, cycle_cnt
    );
endinterface

// File: rtl/tl_ctrl.sv
// Traffic-light sequencer: walks the one-hot phase ring, shortens green on a
// pedestrian request, parks on red while disabled and counts completed cycles.
module tl_ctrl #(
    parameter int STATE_W = 7,
    parameter int CYC_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    tl_ctrl_if.slave bus
);
    typedef enum logic [STATE_W-1:0] {
        G1    = 7'b0000001,
        NONE1 = 7'b0000010,
        G2    = 7'b0000100,
        NONE2 = 7'b0001000,
        G3    = 7'b0010000,
        Y     = 7'b0100000,
        R     = 7'b1000000
    } state_t;

    state_t           state_q, state_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             ack_q, ack_d;
    logic             pend_q, pend_d;
    logic             parked_q, parked_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= G1;
            cnt_rst_q <= 1'b1;
            ack_q     <= 1'b0;
            pend_q    <= 1'b0;
            parked_q  <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_rst_q <= cnt_rst_d;
            ack_q     <= ack_d;
            pend_q    <= pend_d;
            parked_q  <= parked_d;
            cyc_q     <= cyc_d;
        end
    end

    always_comb begin
        // Done flags are stale during the clear cycle, so they are masked there.
        adv       = bus.en & ~cnt_rst_q & (|(bus.done_state & state_q));
        state_d   = state_q;
        cnt_rst_d = adv;
        ack_d     = 1'b0;
        pend_d    = pend_q | (bus.ped_req & ~ack_q);
        parked_d  = 1'b0;
        cyc_d     = cyc_q;

        if (!bus.en) begin
            state_d   = R;
            cnt_rst_d = 1'b1;
            parked_d  = 1'b1;
        end else if (parked_q) begin
            // Leaving park restarts the sequence without counting a cycle.
            state_d   = G1;
            cnt_rst_d = 1'b1;
        end else begin
            case (state_q)
                G1:    if (adv) state_d = pend_q ? Y : NONE1;
                NONE1: if (adv) state_d = pend_q ? Y : G2;
                G2:    if (adv) state_d = pend_q ? Y : NONE2;
                NONE2: if (adv) state_d = pend_q ? Y : G3;
                G3:    if (adv) state_d = Y;
                Y: begin
                    if (adv) begin
                        state_d = R;
                        if (pend_q) begin
                            ack_d  = 1'b1;
                            pend_d = 1'b0;
                        end
                    end
                end
                R: begin
                    if (adv) begin
                        state_d = G1;
                        cyc_d   = cyc_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = G1;
                    cnt_rst_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.curr_state = state_q;
    assign bus.dp_cnt_rst = cnt_rst_q;
    assign bus.ped_ack    = ack_q;
    assign bus.cycle_cnt  = cyc_q;
endmodule

// File: tb/tb_tl_ctrl.sv
// Directed bench for tl_ctrl with a behavioural dp counter supplying done flags.
module tb_tl_ctrl;
    localparam logic [6:0] S_G1 = 7'h01, S_N1 = 7'h02, S_G2 = 7'h04, S_N2 = 7'h08,
                           S_G3 = 7'h10, S_Y = 7'h20, S_R = 7'h40;
    localparam int LIMIT = 4000;

    logic clk;
    logic rst;
    tl_ctrl_if #(.STATE_W(7), .CYC_W(8)) bus ();

    tl_ctrl #(.STATE_W(7), .CYC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dp model: done when count >= thr, giving a dwell of thr+2 cycles.
    logic [10:0] dp_cnt = '0;
    int thr [7];
    always @(posedge clk)
        dp_cnt <= bus.dp_cnt_rst ? 11'd0 : ((dp_cnt == 11'h7ff) ? dp_cnt : dp_cnt + 11'd1);
    always_comb begin
        bus.done_state = '0;
        for (int k = 0; k < 7; k++) bus.done_state[k] = (int'(dp_cnt) >= thr[k]);
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] cur;
        logic [6:0] nxt;
        int         dwell;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_thr(input bit fast);
        if (fast) for (int k = 0; k < 7; k++) thr[k] = 0;
        else begin
            thr[0] = 1023; thr[1] = 127; thr[2] = 127; thr[3] = 127;
            thr[4] = 127;  thr[5] = 511; thr[6] = 1023;
        end
    endtask

    // Called in the first cycle of a phase; returns once the next phase is visible.
    task automatic phase(input string nm, input int raise_at, input logic [6:0] ecur,
                         input logic [6:0] enxt, input int edwell, input int eacks);
        logic [6:0] cur;
        int dwell, pulses, acks, ack_pos;
        cur     = bus.curr_state;
        dwell   = 1;
        pulses  = int'(bus.dp_cnt_rst);
        acks    = int'(bus.ped_ack);
        ack_pos = bus.ped_ack ? 1 : 0;
        if (bus.ped_ack) bus.ped_req = 1'b0;
        if (raise_at == 1) bus.ped_req = 1'b1;
        while (dwell < LIMIT) begin
            @(negedge clk);
            if (bus.curr_state != cur) break;
            dwell++;
            pulses += int'(bus.dp_cnt_rst);
            if (bus.ped_ack) begin
                acks++;
                ack_pos = dwell;
                bus.ped_req = 1'b0;
            end
            if (dwell == raise_at) bus.ped_req = 1'b1;
        end
        check({nm, "_timeout"}, 32'(dwell < LIMIT), 32'd1);
        check({nm, "_cur"}, 32'(cur), 32'(ecur));
        check({nm, "_next"}, 32'(bus.curr_state), 32'(enxt));
        check({nm, "_dwell"}, 32'(dwell), 32'(edwell));
        check({nm, "_clr_pulses"}, 32'(pulses), 32'd1);
        check({nm, "_acks"}, 32'(acks), 32'(eacks));
        if (eacks > 0) check({nm, "_ack_pos"}, 32'(ack_pos), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bad;
        tbl[0] = '{S_G1, S_N1, 1025};
        tbl[1] = '{S_N1, S_G2, 129};
        tbl[2] = '{S_G2, S_N2, 129};
        tbl[3] = '{S_N2, S_G3, 129};
        tbl[4] = '{S_G3, S_Y,  129};
        tbl[5] = '{S_Y,  S_R,  513};
        tbl[6] = '{S_R,  S_G1, 1025};
        set_thr(1'b0);
        rst = 1'b0;
        bus.en = 1'b1;
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.curr_state), 32'(S_G1));
        check("rst_clr", 32'(bus.dp_cnt_rst), 32'd1);
        check("rst_ack", 32'(bus.ped_ack), 32'd0);
        check("rst_cyc", 32'(bus.cycle_cnt), 32'd0);
        rst = 1'b1;

        // Plain cycle from reset release
        for (int i = 0; i < 7; i++)
            phase($sformatf("walk%0d", i), 0, tbl[i].cur, tbl[i].nxt, tbl[i].dwell, 0);
        check("walk_cyc", 32'(bus.cycle_cnt), 32'd1);

        // Request at cycle 100 of G1 skips the green sequence
        phase("pg1_g1", 100, S_G1, S_Y, 1025, 0);
        phase("pg1_y", 0, S_Y, S_R, 513, 0);
        phase("pg1_r", 0, S_R, S_G1, 1025, 1);
        check("pg1_cyc", 32'(bus.cycle_cnt), 32'd2);

        // Following cycle is normal until a request during NONE2
        phase("pn2_g1", 0, S_G1, S_N1, 1025, 0);
        phase("pn2_n1", 0, S_N1, S_G2, 129, 0);
        phase("pn2_g2", 0, S_G2, S_N2, 129, 0);
        phase("pn2_n2", 10, S_N2, S_Y, 129, 0);
        phase("pn2_y", 0, S_Y, S_R, 513, 0);
        phase("pn2_r", 0, S_R, S_G1, 1025, 1);
        check("pn2_cyc", 32'(bus.cycle_cnt), 32'd3);

        // Request during R is served in the next cycle
        for (int i = 0; i < 6; i++)
            phase($sformatf("pr_walk%0d", i), 0, tbl[i].cur, tbl[i].nxt, tbl[i].dwell, 0);
        phase("pr_r", 50, S_R, S_G1, 1025, 0);
        phase("pr_g1", 0, S_G1, S_Y, 1025, 0);
        phase("pr_y", 0, S_Y, S_R, 513, 0);
        phase("pr_r2", 0, S_R, S_G1, 1025, 1);
        check("pr_cyc", 32'(bus.cycle_cnt), 32'd5);

        // Disable in the middle of G2
        phase("en_g1", 0, S_G1, S_N1, 1025, 0);
        phase("en_n1", 0, S_N1, S_G2, 129, 0);
        repeat (60) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check("en_off_state", 32'(bus.curr_state), 32'(S_R));
        check("en_off_clr", 32'(bus.dp_cnt_rst), 32'd1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.curr_state != S_R || bus.dp_cnt_rst != 1'b1 || bus.ped_ack != 1'b0) bad++;
        end
        check("en_hold_bad", 32'(bad), 32'd0);
        bus.en = 1'b1;
        @(negedge clk);
        check("en_on_state", 32'(bus.curr_state), 32'(S_G1));
        check("en_on_cyc", 32'(bus.cycle_cnt), 32'd5);
        phase("en_g1b", 0, S_G1, S_N1, 1025, 0);
        for (int i = 1; i < 7; i++)
            phase($sformatf("en_walk%0d", i), 0, tbl[i].cur, tbl[i].nxt, tbl[i].dwell, 0);
        check("en_cyc", 32'(bus.cycle_cnt), 32'd6);

        // Short phases to reach the counter wrap
        set_thr(1'b1);
        w = 0;
        while (bus.cycle_cnt != 8'd255 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("wrap_reach255", 32'(w < 5000), 32'd1);
        w = 0;
        while (bus.cycle_cnt == 8'd255 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("wrap_cyc", 32'(bus.cycle_cnt), 32'd0);
        check("wrap_state", 32'(bus.curr_state), 32'(S_G1));
        set_thr(1'b0);

        // Asynchronous reset in the middle of Y
        for (int i = 0; i < 5; i++)
            phase($sformatf("ry_walk%0d", i), 0, tbl[i].cur, tbl[i].nxt, tbl[i].dwell, 0);
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ry_state", 32'(bus.curr_state), 32'(S_G1));
        check("ry_clr", 32'(bus.dp_cnt_rst), 32'd1);
        check("ry_ack", 32'(bus.ped_ack), 32'd0);
        check("ry_cyc", 32'(bus.cycle_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        phase("ry_g1", 0, S_G1, S_N1, 1025, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
